// File: rtl/vca_pkg.sv
// Shared constants for the VCA and its downstream mixer: default widths, unity gain, sample limits.
package vca_pkg;

  localparam int BITSIZE     = 16;
  localparam int GAIN_BITS   = 16;
  localparam int UNITY_SHIFT = 14;
  localparam int SLEW_STEP   = 64;

  localparam logic [GAIN_BITS-1:0] UNITY_GAIN = GAIN_BITS'(1 << UNITY_SHIFT);

  localparam logic signed [BITSIZE-1:0] SAMPLE_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic signed [BITSIZE-1:0] SAMPLE_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

endpackage

// File: rtl/vca_saturate.sv
// Combinational floor-shift and clamp of a wide signed product to OUT_W bits; clip flags a clamped value.
// Zero latency, no handshake.
module vca_saturate #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16,
  parameter int SHIFT = 14
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    clip
);

  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  // Arithmetic shift floors toward -inf, so -1 * half gain stays -1.
  assign shifted = in_val >>> SHIFT;

  always_comb begin
    out_val = shifted[OUT_W-1:0];
    clip    = 1'b0;
    if (shifted > MAXV) begin
      out_val = MAXV[OUT_W-1:0];
      clip    = 1'b1;
    end else if (shifted < MINV) begin
      out_val = MINV[OUT_W-1:0];
      clip    = 1'b1;
    end
  end

endmodule

// File: rtl/vca.sv
// Gain stage: sample x envelope gain, 3-cycle pipeline, 1 sample/cycle, valid-only (no backpressure).
// Define VCA_SLEW_EN to rate-limit gain changes to SLEW_STEP per accepted sample.
module vca
  import vca_pkg::*;
#(
  parameter int BITSIZE     = vca_pkg::BITSIZE,
  parameter int GAIN_BITS   = vca_pkg::GAIN_BITS,
  parameter int UNITY_SHIFT = vca_pkg::UNITY_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BITSIZE-1:0]   in_sample,
  input  logic                 in_valid,
  input  logic [GAIN_BITS-1:0] amplitude,
  output logic [BITSIZE-1:0]   out_sample,
  output logic                 out_valid,
  output logic                 clip,
  output logic [GAIN_BITS-1:0] gain
);

  localparam int PW = BITSIZE + GAIN_BITS + 1;

  logic [GAIN_BITS-1:0] g_next;
  logic                 s1_vld, s2_vld;
  logic [BITSIZE-1:0]   s1_sample;
  logic [GAIN_BITS-1:0] s1_gain;
  logic signed [PW-1:0] mul_a, mul_b, prod, s2_prod;
  logic [BITSIZE-1:0]   sat_val;
  logic                 sat_clip;

`ifdef VCA_SLEW_EN
  logic                 up;
  logic [GAIN_BITS-1:0] diff;

  // Direction bit picks the subtraction order so the distance never wraps.
  always_comb begin
    up     = (amplitude >= gain);
    diff   = up ? (amplitude - gain) : (gain - amplitude);
    g_next = amplitude;
    if (diff > GAIN_BITS'(SLEW_STEP))
      g_next = up ? (gain + GAIN_BITS'(SLEW_STEP)) : (gain - GAIN_BITS'(SLEW_STEP));
  end
`else
  assign g_next = amplitude;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gain      <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      out_sample <= '0;
      clip      <= 1'b0;
    end else begin
      if (in_valid) gain <= g_next;
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      clip      <= s2_vld & sat_clip;
      if (s2_vld) out_sample <= sat_val;
    end
  end

  // Datapath registers need no reset; the valids gate everything downstream.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_sample <= in_sample;
      s1_gain   <= g_next;
    end
    s2_prod <= prod;
  end

  // Sign-extended sample times zero-extended gain: the product always fits in PW bits.
  assign mul_a = {{(GAIN_BITS+1){s1_sample[BITSIZE-1]}}, s1_sample};
  assign mul_b = {{(BITSIZE+1){1'b0}}, s1_gain};
  assign prod  = mul_a * mul_b;

  vca_saturate #(
    .IN_W  (PW),
    .OUT_W (BITSIZE),
    .SHIFT (UNITY_SHIFT)
  ) u_sat (
    .in_val  (s2_prod),
    .out_val (sat_val),
    .clip    (sat_clip)
  );

endmodule

// File: tb/tb_vca.sv
// Directed checks of the VCA: reset, scaling, saturation, floor rounding, streaming, mid-stream reset, idle hold.
module tb_vca;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_sample = '0;
  logic        in_valid = 1'b0;
  logic [15:0] amplitude = '0;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        clip;
  logic [15:0] gain;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vca dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .amplitude  (amplitude),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .clip       (clip),
    .gain       (gain)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated sample: checks latency edges, result, clip and the applied gain.
  task automatic run1(input string tag, input logic [15:0] s, input logic [15:0] a,
                      input logic [15:0] exp, input logic exp_clip);
    @(negedge clk);
    in_sample = s; amplitude = a; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_gain"}, 32'(gain), 32'(a));
    @(negedge clk);
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"}, 32'(out_sample), 32'(exp));
    chk({tag, "_clip"}, 32'(clip), 32'(exp_clip));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] held_gain, held_out;

    // Reset with in_valid asserted: nothing may come out.
    rst_n = 1'b0; in_valid = 1'b1; in_sample = 16'h1234; amplitude = 16'h4000;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out_sample), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_clip", 32'(clip), 32'd0);
    chk("rst_gain", 32'(gain), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_ignored_vld", 32'(out_valid), 32'd0);
    end

`ifdef VCA_SLEW_EN
    do_reset();
    for (int k = 0; k < 259; k++) begin
      @(negedge clk);
      if (k == 1) chk("slew_g1", 32'(gain), 32'd64);
      if (k == 2) chk("slew_g2", 32'(gain), 32'd128);
      if (k == 255) chk("slew_g255", 32'(gain), 32'h3FC0);
      if (k == 256) chk("slew_g256", 32'(gain), 32'h3FFF);
      if (k == 3) begin
        chk("slew_first_vld", 32'(out_valid), 32'd1);
        chk("slew_first_out", 32'(out_sample), 32'd64);
      end
      in_sample = 16'h4000; amplitude = 16'h3FFF; in_valid = (k < 256);
    end
    @(negedge clk);
    amplitude = 16'h3FF0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("slew_down_small", 32'(gain), 32'h3FF0);
    @(negedge clk);
    amplitude = 16'h0000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("slew_down_big", 32'(gain), 32'h3FB0);
`else
    run1("half",      16'h4000, 16'h2000, 16'h2000, 1'b0);
    run1("unity",     16'h4000, 16'h4000, 16'h4000, 1'b0);
    run1("sat_pos",   16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1);
    run1("sat_neg",   16'h8000, 16'h8000, 16'h8000, 1'b1);
    run1("min_exact", 16'h8000, 16'h4000, 16'h8000, 1'b0);
    run1("floor_m1",  16'hFFFF, 16'h2000, 16'hFFFF, 1'b0);
    run1("floor_p1",  16'h0001, 16'h2000, 16'h0000, 1'b0);
    run1("zero_gain", 16'h7123, 16'h0000, 16'h0000, 1'b0);
    run1("double",    16'h1000, 16'h8000, 16'h2000, 1'b0);

    // Idle gap: amplitude wiggles but gain and output must hold.
    held_gain = gain;
    held_out  = out_sample;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      amplitude = 16'(16'h1111 * (k + 1));
    end
    @(negedge clk);
    chk("idle_gain", 32'(gain), 32'(held_gain));
    chk("idle_out", 32'(out_sample), 32'(held_out));
    chk("idle_vld", 32'(out_valid), 32'd0);

    // Back-to-back: 8 ramped samples at unity gain.
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk("b2b_vld", 32'(out_valid), 32'((k >= 3 && k <= 10) ? 1 : 0));
        if (k >= 3 && k <= 10) chk("b2b_out", 32'(out_sample), 32'(16'h0100 * (k - 2)));
      end
      in_valid  = (k < 8);
      in_sample = 16'(16'h0100 * (k + 1));
      amplitude = 16'h4000;
    end

    // Reset at cycle 4 discards everything still in flight.
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k >= 1) chk("rst_mid_vld", 32'(out_valid), 32'((k == 3 || k == 4) ? 1 : 0));
      if (k == 4) chk("rst_mid_out", 32'(out_sample), 32'h0200);
      rst_n     = (k != 4);
      in_valid  = (k <= 4);
      in_sample = 16'(16'h0100 * (k + 1));
      amplitude = 16'h4000;
    end
    chk("rst_mid_final_out", 32'(out_sample), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vca.md
# vca

Voltage-controlled amplifier stage that sits directly downstream of `envelope_generator`. It multiplies each oscillator sample by the envelope's `amplitude` word, with optional gain slew limiting to suppress zipper noise. It produces a saturated, signed sample for the mixer/output stage. The multiplier is a fully pipelined 3-stage datapath with a valid-only handshake: one sample per `in_valid` pulse, back-to-back accepted.

## Interface
- `BITSIZE`, 16: sample width in and out, signed two's complement.
- `GAIN_BITS`, 16: width of `amplitude`, unsigned.
- `UNITY_SHIFT`, 14: gain fixed point; `amplitude == 2**UNITY_SHIFT` is unity. The envelope full scale is 0x3FFF, just under unity.
- `SLEW_STEP`, 64: maximum gain change per accepted sample. Used only with `VCA_SLEW_EN`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_sample`  in  BITSIZE  signed oscillator sample.
- `in_valid`  in  1  one-cycle qualifier for `in_sample`; may be high every cycle.
- `amplitude`  in  GAIN_BITS  target gain from the envelope generator, sampled only when `in_valid`=1.
- `out_sample`  out  BITSIZE  scaled, saturated sample; holds its value between valids.
- `out_valid`  out  1  one-cycle qualifier for `out_sample`.
- `clip`  out  1  high with `out_valid` when that sample saturated; otherwise 0.
- `gain`  out  GAIN_BITS  gain currently applied (slewed value or raw target), for debug.

## Operation
- No ready/backpressure: every `in_valid` produces exactly one `out_valid`, in order.
- Gain update happens on each `in_valid` cycle:
  - Compute `g_next` from `gain` and `amplitude`.
  - Register `g_next` into `gain`.
  - The sample captured in the same cycle is scaled by `g_next`, not by the old gain.
- Stage 1 registers `in_sample`, `g_next` and valid.
- Stage 2 forms the full product: signed sample × unsigned gain, computed as a BITSIZE+GAIN_BITS+1-bit signed value. The gain is zero-extended.
- Stage 3:
  - Arithmetic right shift by UNITY_SHIFT, which floors toward −inf.
  - Saturate to [−2^(BITSIZE−1), 2^(BITSIZE−1)−1].
  - Set `clip` if the value was out of range.
  - Register `out_sample`, `out_valid` and `clip`.
- `gain` is unchanged on cycles with `in_valid`=0.
- A gain of 0 produces an exact 0 output. Gains above unity are legal and may clip.

## Timing
- Latency from `in_valid` to `out_valid` is exactly 3 cycles. Throughput is 1 sample per cycle.
- Reset values: `out_sample`=0, `out_valid`=0, `clip`=0, `gain`=0, and all pipeline valids 0.
- Reset asserted mid-operation discards in-flight samples: no `out_valid` for them, even if `rst_n` rises one cycle later.
- An `in_valid` sampled while `rst_n`=0 is ignored.

## Configuration
- `VCA_SLEW_EN` defined:
  - If |`amplitude` − `gain`| ≤ SLEW_STEP, then `g_next` = `amplitude`.
  - Otherwise `g_next` = `gain` ± SLEW_STEP, moving toward `amplitude`.
  - The comparison is done without overflow: unsigned subtract with direction bit.
- `VCA_SLEW_EN` undefined: `g_next` = `amplitude`, and the slew logic is absent.
- Latency is identical in both builds.

## Structure
- Shared package `vca_pkg` holds:
  - the default width constants;
  - the unity-gain constant (1 << UNITY_SHIFT);
  - a saturation-limit function or constants for BITSIZE.
- One sub-module, `vca_saturate`: combinational shift + clamp + clip flag, used in stage 3 and reusable by the mixer.

## Test plan
- Unity/half gain, no slew: `in_sample`=0x4000, `amplitude`=0x2000 → 3 cycles later `out_sample`=0x2000, `clip`=0. With `amplitude`=0x4000 the same input gives 0x4000.
- Saturation:
  - 0x7FFF × 0xFFFF → 0x7FFF, `clip`=1.
  - 0x8000 × 0x8000 → 0x8000, `clip`=1.
  - 0x8000 × 0x4000 → 0x8000, `clip`=0.
- Floor rounding: `in_sample`=−1 (0xFFFF), `amplitude`=0x2000 → `out_sample`=0xFFFF (−1). With `in_sample`=+1 → 0x0000.
- Back-to-back: `in_valid` held 8 cycles with ramped samples → 8 consecutive `out_valid` cycles, in order, starting at cycle 3. Asserting `rst_n`=0 at cycle 4 drops all remaining outputs.
- Slew (`VCA_SLEW_EN`):
  - From reset, constant `amplitude`=0x3FFF → `gain` = 64, 128, … per `in_valid`, reaching 0x3FFF on the 256th sample.
  - First output for `in_sample`=0x4000 is 64.
  - Then `amplitude`=0x3FF0 → `gain`=0x3FF0 in one sample.
- Idle gaps: `in_valid` low for 10 cycles while `amplitude` changes → `gain` unchanged, and `out_sample` holds its last value.
